// File: rtl/iob_axi_m_read_axis_burst.sv
// AXI4 read master that streams a beat-aligned memory region out as AXI-Stream.
// Each burst is sized so it always fits in the output FIFO, which lets RREADY stay high for the whole burst.
module iob_axi_m_read_axis_burst #(
    parameter int unsigned AXI_ADDR_W  = 32,
    parameter int unsigned AXI_DATA_W  = 32,
    parameter int unsigned AXI_LEN_W   = 8,
    parameter int unsigned AXI_ID_W    = 1,
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned LENGTH_W    = 16,
    parameter int unsigned FIFO_ADDR_W = 4
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_n_i,
    input  logic [AXI_ADDR_W-1:0] r_addr_i,
    input  logic [LENGTH_W-1:0]   r_length_i,
    input  logic                  r_start_transfer_i,
    output logic                  r_busy_o,
    output logic                  r_error_o,
    output logic [AXI_DATA_W-1:0] axis_out_data_o,
    output logic                  axis_out_valid_o,
    input  logic                  axis_out_ready_i,
    output logic                  axis_out_last_o,
    output logic [AXI_ADDR_W-1:0] axi_araddr_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [AXI_ID_W-1:0]   axi_arid_o,
    output logic [AXI_LEN_W-1:0]  axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic                  axi_arlock_o,
    output logic [3:0]            axi_arcache_o,
    output logic [3:0]            axi_arqos_o,
    input  logic [AXI_DATA_W-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    input  logic [AXI_ID_W-1:0]   axi_rid_i,
    input  logic                  axi_rlast_i
);
    localparam int unsigned BYTES = AXI_DATA_W / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);
    localparam int unsigned DEPTH = 2 ** FIFO_ADDR_W;
    localparam int unsigned LVL_W = FIFO_ADDR_W + 1;
    localparam int unsigned W_A   = (LENGTH_W + 1 > 14) ? LENGTH_W + 1 : 14;
    localparam int unsigned W_B   = (LVL_W + 1 > AXI_LEN_W + 2) ? LVL_W + 1 : AXI_LEN_W + 2;
    localparam int unsigned CNT_W = (W_A > W_B) ? W_A : W_B;

    typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [LENGTH_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]      blen_q, blen_d;
    logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
    logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;

    logic [AXI_DATA_W-1:0]  mem_data [DEPTH];
    logic                   mem_last [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   out_valid_q;

    logic                   push_c, pop_c, last_in_c;
    logic [12:0]            to_4k_bytes_c;
    logic [CNT_W-1:0]       beats_4k_c, rem_ext_c, max_burst_c, blen_c, free_c;
    logic                   unused_rid;

    assign unused_rid = ^axi_rid_i;

    // Burst sizing: smallest of remaining length, burst cap and distance to the 4 KiB page end
    assign to_4k_bytes_c = 13'h1000 - {1'b0, addr_q[11:0]};
    assign beats_4k_c    = CNT_W'(to_4k_bytes_c >> SIZE);
    assign rem_ext_c     = CNT_W'(rem_q);
    assign max_burst_c   = CNT_W'(MAX_BURST);
    assign free_c        = CNT_W'(DEPTH) - CNT_W'(level_q);

    always_comb begin
        blen_c = rem_ext_c;
        if (max_burst_c < blen_c) blen_c = max_burst_c;
        if (beats_4k_c < blen_c)  blen_c = beats_4k_c;
    end

    // FIFO control; a full FIFO still accepts a beat when the head pops in the same cycle
    assign pop_c     = cke_i && out_valid_q && axis_out_ready_i;
    assign push_c    = cke_i && (state_q == DATA) && rready_q && axi_rvalid_i
                       && ((level_q != LVL_W'(DEPTH)) || pop_c);
    assign last_in_c = axi_rlast_i && (rem_q == '0);
    assign level_d   = level_q + LVL_W'(push_c) - LVL_W'(pop_c);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        blen_d    = blen_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        error_d   = error_q;
        unique case (state_q)
            IDLE: begin
                if (r_start_transfer_i && (r_length_i != '0)) begin
                    addr_d  = r_addr_i & ~AXI_ADDR_W'(BYTES - 1);
                    rem_d   = r_length_i;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (free_c >= blen_c) begin
                    blen_d    = blen_c;
                    araddr_d  = addr_q;
                    arlen_d   = AXI_LEN_W'(blen_c - CNT_W'(1));
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (axi_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    rem_d     = rem_q - LENGTH_W'(blen_q);
                    addr_d    = addr_q + (AXI_ADDR_W'(blen_q) << SIZE);
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (axi_rvalid_i) begin
                    if (axi_rresp_i != 2'b00) error_d = 1'b1;
                    if (axi_rlast_i) begin
                        rready_d = 1'b0;
                        state_d  = (rem_q != '0) ? CALC : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (level_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            blen_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            blen_q    <= blen_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (cke_i) begin
            if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_ADDR_W'(1);
            level_q     <= level_d;
            out_valid_q <= (level_d != '0);
        end
    end

    // Storage array needs no reset; validity comes from the level counter
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_data[wr_ptr_q] <= axi_rdata_i;
            mem_last[wr_ptr_q] <= last_in_c;
        end
    end

    assign axis_out_data_o  = mem_data[rd_ptr_q];
    assign axis_out_valid_o = out_valid_q;
    assign axis_out_last_o  = out_valid_q & mem_last[rd_ptr_q];

    assign r_busy_o      = busy_q;
    assign r_error_o     = error_q;
    assign axi_araddr_o  = araddr_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_arlen_o   = arlen_q;
    assign axi_rready_o  = rready_q;
    assign axi_arid_o    = '0;
    assign axi_arsize_o  = 3'(SIZE);
    assign axi_arburst_o = 2'b01;
    assign axi_arlock_o  = 1'b0;
    assign axi_arcache_o = 4'd2;
    assign axi_arqos_o   = 4'd0;

endmodule

// File: tb/tb_iob_axi_m_read_axis_burst.sv
// Scoreboard bench: expected AR requests and stream beats are queued at stimulus time
// and popped by independent monitors; a small AXI slave model serves the reads.
module tb_iob_axi_m_read_axis_burst;

    typedef struct {logic [31:0] data; logic last;} beat_t;
    typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
    typedef struct {logic [31:0] addr; int len;} burst_t;

    logic        clk = 1'b0;
    logic        cke, rst_n;
    logic [31:0] r_addr;
    logic [15:0] r_length;
    logic        r_start, r_busy, r_error;
    logic [31:0] axis_data;
    logic        axis_valid, axis_ready, axis_last;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [0:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache, arqos;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready, rlast;
    logic [0:0]  rid;

    int n_checks = 0;
    int n_fail   = 0;
    int ar_seen  = 0;
    int beats_in = 0;
    int beats_out = 0;
    int err_at   = -1;
    logic bp_check = 1'b0;

    beat_t  exp_q[$];
    ar_t    exp_ar[$];
    burst_t bursts[$];

    always #5 clk = ~clk;

    iob_axi_m_read_axis_burst dut (
        .clk_i(clk), .cke_i(cke), .arst_n_i(rst_n),
        .r_addr_i(r_addr), .r_length_i(r_length), .r_start_transfer_i(r_start),
        .r_busy_o(r_busy), .r_error_o(r_error),
        .axis_out_data_o(axis_data), .axis_out_valid_o(axis_valid),
        .axis_out_ready_i(axis_ready), .axis_out_last_o(axis_last),
        .axi_araddr_o(araddr), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_arid_o(arid), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
        .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache),
        .axi_arqos_o(arqos),
        .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rvalid_i(rvalid),
        .axi_rready_o(rready), .axi_rid_i(rid), .axi_rlast_i(rlast)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        exp_ar.push_back(e);
    endtask

    task automatic expect_xfer(input logic [31:0] a, input int n);
        beat_t e;
        logic [31:0] b;
        b = a & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            e.data = mem_word(b + 32'(4 * i));
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_xfer(input logic [31:0] a, input int n);
        r_addr   = a;
        r_length = 16'(n);
        r_start  = 1'b1;
        tick();
        r_start  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (r_busy && i < 3000) begin
            tick();
            i++;
        end
        chk({name, "_busy_drop"}, 64'(r_busy), 64'(0));
        chk({name, "_beats_left"}, 64'(exp_q.size()), 64'(0));
        chk({name, "_ar_left"}, 64'(exp_ar.size()), 64'(0));
    endtask

    // AR channel monitor
    initial begin
        ar_t e;
        forever begin
            @(negedge clk);
            if (rst_n && arvalid && arready) begin
                ar_seen++;
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", 64'(araddr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_ar.pop_front();
                    chk("araddr", 64'(araddr), 64'(e.addr));
                    chk("arlen", 64'(arlen), 64'(e.len));
                    chk("arsize_burst", 64'({arsize, arburst}), 64'({3'd2, 2'd1}));
                    chk("ar_consts", 64'({arid, arlock, arcache, arqos}), 64'({1'b0, 1'b0, 4'd2, 4'd0}));
                end
            end
        end
    end

    // AXIS output monitor
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && axis_valid && axis_ready) begin
                beats_out++;
                if (exp_q.size() == 0) begin
                    chk("axis_unexpected", 64'(axis_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("axis_data", 64'(axis_data), 64'(e.data));
                    chk("axis_last", 64'(axis_last), 64'(e.last));
                end
            end
        end
    end

    // AXI read slave model
    initial begin
        logic   ar_hs, r_hs;
        burst_t nb;
        int     beat_idx;
        beat_idx = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
        forever begin
            @(negedge clk);
            ar_hs = rst_n && arvalid && arready;
            r_hs  = rst_n && rvalid && rready;
            if (ar_hs) begin
                nb.addr = araddr;
                nb.len  = int'(arlen) + 1;
            end
            if (rst_n && bursts.size() > 0) chk("rready_in_burst", 64'(rready), 64'(1));
            if (bp_check) chk("fifo_bound", 64'((beats_in - beats_out) <= 16), 64'(1));
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bursts.delete();
                beat_idx = 0;
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                continue;
            end
            if (r_hs) begin
                beats_in++;
                beat_idx++;
                if (beat_idx == bursts[0].len) begin
                    void'(bursts.pop_front());
                    beat_idx = 0;
                end
            end
            if (ar_hs) bursts.push_back(nb);
            arready = 1'($urandom_range(0, 1));
            if (!(rvalid && !r_hs)) begin
                if (bursts.size() > 0 && $urandom_range(0, 3) != 0) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(bursts[0].addr + 32'(4 * beat_idx));
                    rlast  = (beat_idx == bursts[0].len - 1);
                    rresp  = (beats_in == err_at) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                    rresp  = 2'b00;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar_before;
        rst_n = 1'b0; cke = 1'b1; r_start = 1'b0; r_addr = '0; r_length = '0; axis_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy_err", 64'({r_busy, r_error}), 64'(0));
        chk("rst_ar", 64'({arvalid, rready, araddr, arlen}), 64'(0));
        chk("rst_axis", 64'({axis_valid, axis_last}), 64'(0));
        #2 rst_n = 1'b1;
        tick();

        // single burst
        push_ar(32'h1000, 8'd7);
        expect_xfer(32'h1000, 8);
        start_xfer(32'h1000, 8);
        chk("t1_busy_rise", 64'(r_busy), 64'(1));
        chk("t1_arvalid_lat1", 64'(arvalid), 64'(0));
        tick();
        chk("t1_arvalid_lat2", 64'(arvalid), 64'(1));
        wait_idle("t1");

        // 4 KiB split
        push_ar(32'h0FF8, 8'd1);
        push_ar(32'h1000, 8'd3);
        expect_xfer(32'h0FF8, 6);
        start_xfer(32'h0FF8, 6);
        wait_idle("t2");

        // three bursts capped by MAX_BURST
        push_ar(32'h3000, 8'd15);
        push_ar(32'h3040, 8'd15);
        push_ar(32'h3080, 8'd7);
        expect_xfer(32'h3000, 40);
        start_xfer(32'h3000, 40);
        wait_idle("t3");

        // output backpressure holds the second AR until space frees
        axis_ready = 1'b0;
        bp_check   = 1'b1;
        ar_before  = ar_seen;
        push_ar(32'h4000, 8'd15);
        push_ar(32'h4040, 8'd15);
        push_ar(32'h4080, 8'd7);
        expect_xfer(32'h4000, 40);
        start_xfer(32'h4000, 40);
        repeat (50) tick();
        chk("t4_ar_withheld", 64'(ar_seen - ar_before), 64'(1));
        chk("t4_buffered", 64'(beats_in - beats_out), 64'(16));
        axis_ready = 1'b1;
        wait_idle("t4");
        bp_check = 1'b0;
        chk("t4_no_error", 64'(r_error), 64'(0));

        // SLVERR on beat 3 of 8
        err_at = beats_in + 2;
        push_ar(32'h5000, 8'd7);
        expect_xfer(32'h5000, 8);
        start_xfer(32'h5000, 8);
        wait_idle("t5");
        err_at = -1;
        chk("t5_error_sticky", 64'(r_error), 64'(1));

        // zero length is ignored
        ar_before = ar_seen;
        start_xfer(32'h9000, 0);
        chk("t6_busy", 64'(r_busy), 64'(0));
        repeat (4) tick();
        chk("t6_busy_later", 64'(r_busy), 64'(0));
        chk("t6_no_ar", 64'(ar_seen - ar_before), 64'(0));
        chk("t6_error_kept", 64'(r_error), 64'(1));

        // reset during data phase
        push_ar(32'h6000, 8'd15);
        expect_xfer(32'h6000, 40);
        start_xfer(32'h6000, 40);
        chk("t7_error_cleared", 64'(r_error), 64'(0));
        repeat (12) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_busy_err", 64'({r_busy, r_error}), 64'(0));
        chk("t7_rst_ar", 64'({arvalid, rready, araddr, arlen}), 64'(0));
        chk("t7_rst_axis", 64'({axis_valid, axis_last}), 64'(0));
        exp_q.delete();
        exp_ar.delete();
        repeat (3) tick();
        beats_out = beats_in;
        #2 rst_n = 1'b1;
        tick();

        // unaligned start after reset, split at the page end
        push_ar(32'h7FF4, 8'd2);
        push_ar(32'h8000, 8'd1);
        expect_xfer(32'h7FF6, 5);
        start_xfer(32'h7FF6, 5);
        wait_idle("t8");
        chk("t8_error", 64'(r_error), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
